// File: rtl/crack_result_if.sv
// Handshake, key and display bundle between the crack result controller and its environment.
interface crack_result_if #(
  parameter int unsigned CNT_W = 32
);
  logic             start;
  logic             crack_rdy;
  logic             crack_en;
  logic [23:0]      key;
  logic             key_valid;
  logic [6:0]       HEX0;
  logic [6:0]       HEX1;
  logic [6:0]       HEX2;
  logic [6:0]       HEX3;
  logic [6:0]       HEX4;
  logic [6:0]       HEX5;
  logic             busy;
  logic             found;
  logic             failed;
  logic [CNT_W-1:0] cycles;

  // Controller side
  modport master (
    input  start, crack_rdy, key, key_valid,
    output crack_en, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, busy, found, failed, cycles
  );

  // Environment side (engine, push-button, display)
  modport slave (
    output start, crack_rdy, key, key_valid,
    input  crack_en, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, busy, found, failed, cycles
  );
endinterface

// File: rtl/crack_result_ctrl.sv
// Sequences one crack-engine run and shows the found key (or a failure) on six 7-segment digits.
module crack_result_ctrl #(
  parameter bit          AUTO_START = 1'b1,
  parameter int unsigned CNT_W      = 32
) (
  input logic            clk,
  input logic            rst,
  crack_result_if.master bus
);
  localparam int unsigned KEY_W     = 24;
  localparam int unsigned DIGITS    = 6;
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;
  localparam logic [6:0]  SEG_DASH  = 7'b0111111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WLOW  = 3'd2,
    S_WHIGH = 3'd3,
    S_SHOW  = 3'd4,
    S_FAIL  = 3'd5
  } state_t;

  state_t                 state, state_nxt;
  logic                   boot;
  logic [KEY_W-1:0]       key_q, key_nxt;
  logic                   en_q, en_nxt;
  logic                   busy_q, busy_nxt;
  logic                   found_q, found_nxt;
  logic                   failed_q, failed_nxt;
  logic [CNT_W-1:0]       cnt_q, cnt_nxt;
  logic [DIGITS-1:0][6:0] hex_q, hex_nxt;
  logic                   run_c;

  // Active-low hex digit encoding, bit6=g .. bit0=a
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  assign run_c = (state == S_REQ) || (state == S_WLOW) || (state == S_WHIGH);

  // State and output registers; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      boot     <= 1'b1;
      key_q    <= '0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      found_q  <= 1'b0;
      failed_q <= 1'b0;
      cnt_q    <= '0;
      hex_q    <= {DIGITS{SEG_BLANK}};
    end else begin
      state    <= state_nxt;
      boot     <= 1'b0;
      key_q    <= key_nxt;
      en_q     <= en_nxt;
      busy_q   <= busy_nxt;
      found_q  <= found_nxt;
      failed_q <= failed_nxt;
      cnt_q    <= cnt_nxt;
      hex_q    <= hex_nxt;
    end
  end

  // Next state; WLOW waits for rdy to drop so a stale high rdy is not read as completion
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:         if (bus.start || (AUTO_START && boot)) state_nxt = S_REQ;
      S_REQ:          if (bus.crack_rdy) state_nxt = S_WLOW;
      S_WLOW:         if (!bus.crack_rdy) state_nxt = S_WHIGH;
      S_WHIGH:        if (bus.crack_rdy) state_nxt = bus.key_valid ? S_SHOW : S_FAIL;
      S_SHOW, S_FAIL: if (bus.start) state_nxt = S_REQ;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, aligned with the state being entered
  always_comb begin
    key_nxt    = key_q;
    en_nxt     = 1'b0;
    cnt_nxt    = cnt_q;
    busy_nxt   = (state_nxt == S_REQ) || (state_nxt == S_WLOW) || (state_nxt == S_WHIGH);
    found_nxt  = (state_nxt == S_SHOW);
    failed_nxt = (state_nxt == S_FAIL);
    hex_nxt    = {DIGITS{SEG_BLANK}};
    if ((state == S_WHIGH) && (state_nxt == S_SHOW)) key_nxt = bus.key;
    if ((state == S_REQ) && bus.crack_rdy) en_nxt = 1'b1;
    if (!run_c && (state_nxt == S_REQ)) cnt_nxt = '0;
    else if (run_c && !(&cnt_q)) cnt_nxt = cnt_q + CNT_W'(1);
    for (int n = 0; n < DIGITS; n++) begin
      if (found_nxt) hex_nxt[n] = seg7(key_nxt[4*n +: 4]);
      else if (failed_nxt) hex_nxt[n] = SEG_DASH;
    end
  end

  assign bus.crack_en = en_q;
  assign bus.busy     = busy_q;
  assign bus.found    = found_q;
  assign bus.failed   = failed_q;
  assign bus.cycles   = cnt_q;
  assign bus.HEX0     = hex_q[0];
  assign bus.HEX1     = hex_q[1];
  assign bus.HEX2     = hex_q[2];
  assign bus.HEX3     = hex_q[3];
  assign bus.HEX4     = hex_q[4];
  assign bus.HEX5     = hex_q[5];
endmodule

// File: tb/tb_crack_result_ctrl.sv
// Self-checking bench for crack_result_ctrl with a behavioural engine and display model.
module tb_crack_result_ctrl;
  localparam int unsigned CNT_W = 32;
  localparam int M_BLANK = 0;
  localparam int M_SHOW  = 1;
  localparam int M_FAIL  = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  int   en_pulses = 0;
  int   entry_edge = 0;

  always #5 clk = ~clk;

  crack_result_if #(.CNT_W(CNT_W)) bus ();

  crack_result_ctrl #(.AUTO_START(1'b1), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Rising-edge index and crack_en pulse count
  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (bus.crack_en === 1'b1) en_pulses <= en_pulses + 1;
  end

  // Hard stop if the bench itself stalls
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
          7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[d];
  endfunction

  // Expected {HEX5..HEX0} for a display mode
  function automatic logic [41:0] exp_hex(input int mode, input logic [23:0] k);
    logic [41:0] r;
    for (int n = 0; n < 6; n++) begin
      if (mode == M_SHOW) r[7*n +: 7] = seg_ref(k[4*n +: 4]);
      else if (mode == M_FAIL) r[7*n +: 7] = 7'b0111111;
      else r[7*n +: 7] = 7'b1111111;
    end
    return r;
  endfunction

  function automatic logic [41:0] hex_all();
    return {bus.HEX5, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
  endfunction

  function automatic logic [3:0] status();
    return {bus.busy, bus.found, bus.failed, bus.crack_en};
  endfunction

  // Engine model: ready until crack_en, optional stale-high period, low for low_len cycles,
  // then ready with the result; random key/key_valid (and start if poke) while not relevant
  task automatic engine_run(input bit kv, input logic [23:0] k, input int low_len,
                            input int stale_hi, input bit poke,
                            output int exit_edge, output bit tmo, output int stale_bad);
    int n;
    tmo = 1'b0;
    stale_bad = 0;
    exit_edge = 0;
    bus.crack_rdy = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      bus.key = 24'($urandom);
      bus.key_valid = 1'($urandom);
      if (poke) bus.start = 1'($urandom);
    end while (bus.crack_en !== 1'b1 && n < 40);
    if (bus.crack_en !== 1'b1) begin
      tmo = 1'b1;
      bus.start = 1'b0;
      return;
    end
    repeat (stale_hi) begin
      @(negedge clk);
      if (status() !== 4'b1000) stale_bad++;
      bus.key = 24'($urandom);
      bus.key_valid = 1'($urandom);
      if (poke) bus.start = 1'($urandom);
    end
    bus.crack_rdy = 1'b0;
    repeat (low_len) begin
      @(negedge clk);
      bus.key = 24'($urandom);
      bus.key_valid = 1'($urandom);
      if (poke) bus.start = 1'($urandom);
    end
    bus.start = 1'b0;
    bus.crack_rdy = 1'b1;
    bus.key_valid = kv;
    bus.key = k;
    exit_edge = edge_cnt + 1;
    @(negedge clk);
    bus.key = 24'($urandom);
    bus.key_valid = 1'($urandom);
  endtask

  // One-cycle start pulse from SHOW/FAIL
  task automatic pulse_start();
    bus.start = 1'b1;
    entry_edge = edge_cnt + 1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.crack_rdy = 1'b0;
    bus.key = '0;
    bus.key_valid = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.crack_rdy = 1'(i);
      bus.start = 1'(i >> 1);
      bus.key_valid = 1'b1;
      bus.key = 24'($urandom);
      @(negedge clk);
    end
    bus.start = 1'b0;
    checks++; if (bus.crack_en !== 1'b0) begin errors++; $display("FAIL reset crack_en got=%b exp=0", bus.crack_en); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy got=%b exp=0", bus.busy); end
    checks++; if (bus.found !== 1'b0) begin errors++; $display("FAIL reset found got=%b exp=0", bus.found); end
    checks++; if (bus.failed !== 1'b0) begin errors++; $display("FAIL reset failed got=%b exp=0", bus.failed); end
    checks++; if (bus.cycles !== '0) begin errors++; $display("FAIL reset cycles got=%0d exp=0", bus.cycles); end
    checks++; if (hex_all() !== exp_hex(M_BLANK, '0)) begin errors++; $display("FAIL reset hex got=%h exp=%h", hex_all(), exp_hex(M_BLANK, '0)); end
    checks++; if (en_pulses !== 0) begin errors++; $display("FAIL reset en_pulses got=%0d exp=0", en_pulses); end
  endtask

  // rdy low after reset: no crack_en until rdy rises, then exactly one pulse
  task automatic test_rdy_held_low();
    int p0, ex, sb, bad_en, bad_busy;
    bit tmo;
    logic [23:0] k;
    bad_en = 0;
    bad_busy = 0;
    bus.crack_rdy = 1'b0;
    entry_edge = edge_cnt + 1;
    rst = 1'b0;
    p0 = en_pulses;
    repeat (20) begin
      @(negedge clk);
      if (bus.crack_en !== 1'b0) bad_en++;
      if (bus.busy !== 1'b1) bad_busy++;
    end
    checks++; if (bad_en != 0) begin errors++; $display("FAIL rdy_low crack_en_high_cycles got=%0d exp=0", bad_en); end
    checks++; if (bad_busy != 0) begin errors++; $display("FAIL rdy_low not_busy_cycles got=%0d exp=0", bad_busy); end
    checks++; if (bus.cycles !== 32'(edge_cnt - entry_edge)) begin errors++; $display("FAIL rdy_low cycles_running got=%0d exp=%0d", bus.cycles, edge_cnt - entry_edge); end
    k = 24'($urandom);
    engine_run(1'b1, k, int'($urandom_range(2, 8)), 0, 1'b0, ex, tmo, sb);
    checks++; if (tmo) begin errors++; $display("FAIL rdy_low timeout got=1 exp=0"); end
    checks++; if (en_pulses - p0 != 1) begin errors++; $display("FAIL rdy_low pulses got=%0d exp=1", en_pulses - p0); end
    checks++; if (status() !== 4'b0100) begin errors++; $display("FAIL rdy_low status got=%b exp=0100", status()); end
    checks++; if (hex_all() !== exp_hex(M_SHOW, k)) begin errors++; $display("FAIL rdy_low hex got=%h exp=%h", hex_all(), exp_hex(M_SHOW, k)); end
    checks++; if (bus.cycles !== 32'(ex - entry_edge)) begin errors++; $display("FAIL rdy_low cycles got=%0d exp=%0d", bus.cycles, ex - entry_edge); end
  endtask

  // Auto-start after reset, 100-cycle engine run, key 00033C displayed and held
  task automatic test_found_key();
    int p0, ex, sb;
    bit tmo;
    logic [41:0] hx;
    logic [31:0] cy;
    rst = 1'b1;
    bus.crack_rdy = 1'b1;
    repeat (2) @(negedge clk);
    entry_edge = edge_cnt + 1;
    rst = 1'b0;
    p0 = en_pulses;
    @(negedge clk);
    checks++; if (status() !== 4'b1000) begin errors++; $display("FAIL found_key req_status got=%b exp=1000", status()); end
    engine_run(1'b1, 24'h00033C, 100, 0, 1'b0, ex, tmo, sb);
    checks++; if (tmo) begin errors++; $display("FAIL found_key timeout got=1 exp=0"); end
    checks++; if (en_pulses - p0 != 1) begin errors++; $display("FAIL found_key pulses got=%0d exp=1", en_pulses - p0); end
    checks++; if (status() !== 4'b0100) begin errors++; $display("FAIL found_key status got=%b exp=0100", status()); end
    checks++; if (hex_all() !== exp_hex(M_SHOW, 24'h00033C)) begin errors++; $display("FAIL found_key hex got=%h exp=%h", hex_all(), exp_hex(M_SHOW, 24'h00033C)); end
    checks++; if (bus.cycles !== 32'(ex - entry_edge)) begin errors++; $display("FAIL found_key cycles got=%0d exp=%0d", bus.cycles, ex - entry_edge); end
    hx = exp_hex(M_SHOW, 24'h00033C);
    cy = 32'(ex - entry_edge);
    repeat (4) begin
      bus.crack_rdy = 1'($urandom);
      bus.key = 24'($urandom);
      bus.key_valid = 1'($urandom);
      @(negedge clk);
    end
    bus.crack_rdy = 1'b1;
    checks++; if ({hex_all(), bus.cycles, status()} !== {hx, cy, 4'b0100}) begin errors++; $display("FAIL found_key hold got=%h/%0d/%b exp=%h/%0d/0100", hex_all(), bus.cycles, status(), hx, cy); end
  endtask

  // Re-run from SHOW blanks the display; engine reports no key
  task automatic test_fail();
    int p0, ex, sb;
    bit tmo;
    p0 = en_pulses;
    pulse_start();
    checks++; if (status() !== 4'b1000) begin errors++; $display("FAIL fail_run restart_status got=%b exp=1000", status()); end
    checks++; if (hex_all() !== exp_hex(M_BLANK, '0)) begin errors++; $display("FAIL fail_run restart_hex got=%h exp=%h", hex_all(), exp_hex(M_BLANK, '0)); end
    checks++; if (bus.cycles !== '0) begin errors++; $display("FAIL fail_run restart_cycles got=%0d exp=0", bus.cycles); end
    engine_run(1'b0, 24'($urandom), int'($urandom_range(1, 10)), 0, 1'b0, ex, tmo, sb);
    checks++; if (tmo) begin errors++; $display("FAIL fail_run timeout got=1 exp=0"); end
    checks++; if (en_pulses - p0 != 1) begin errors++; $display("FAIL fail_run pulses got=%0d exp=1", en_pulses - p0); end
    checks++; if (status() !== 4'b0010) begin errors++; $display("FAIL fail_run status got=%b exp=0010", status()); end
    checks++; if (hex_all() !== exp_hex(M_FAIL, '0)) begin errors++; $display("FAIL fail_run hex got=%h exp=%h", hex_all(), exp_hex(M_FAIL, '0)); end
    checks++; if (bus.cycles !== 32'(ex - entry_edge)) begin errors++; $display("FAIL fail_run cycles got=%0d exp=%0d", bus.cycles, ex - entry_edge); end
  endtask

  // rdy still high for 5 cycles after crack_en must not count as completion
  task automatic test_stale_rdy();
    int p0, ex, sb;
    bit tmo;
    logic [23:0] k;
    p0 = en_pulses;
    pulse_start();
    k = 24'($urandom);
    engine_run(1'b1, k, 4, 5, 1'b0, ex, tmo, sb);
    checks++; if (tmo) begin errors++; $display("FAIL stale_rdy timeout got=1 exp=0"); end
    checks++; if (sb != 0) begin errors++; $display("FAIL stale_rdy early_completion_cycles got=%0d exp=0", sb); end
    checks++; if (en_pulses - p0 != 1) begin errors++; $display("FAIL stale_rdy pulses got=%0d exp=1", en_pulses - p0); end
    checks++; if (status() !== 4'b0100) begin errors++; $display("FAIL stale_rdy status got=%b exp=0100", status()); end
    checks++; if (hex_all() !== exp_hex(M_SHOW, k)) begin errors++; $display("FAIL stale_rdy hex got=%h exp=%h", hex_all(), exp_hex(M_SHOW, k)); end
    checks++; if (bus.cycles !== 32'(ex - entry_edge)) begin errors++; $display("FAIL stale_rdy cycles got=%0d exp=%0d", bus.cycles, ex - entry_edge); end
  endtask

  // Start pulses while busy are ignored: one crack_en per run
  task automatic test_start_while_busy();
    int p0, ex, sb;
    bit tmo;
    logic [23:0] k;
    p0 = en_pulses;
    pulse_start();
    k = 24'($urandom);
    engine_run(1'b1, k, 12, 2, 1'b1, ex, tmo, sb);
    repeat (3) @(negedge clk);
    checks++; if (tmo) begin errors++; $display("FAIL busy_start timeout got=1 exp=0"); end
    checks++; if (en_pulses - p0 != 1) begin errors++; $display("FAIL busy_start pulses got=%0d exp=1", en_pulses - p0); end
    checks++; if (status() !== 4'b0100) begin errors++; $display("FAIL busy_start status got=%b exp=0100", status()); end
    checks++; if (hex_all() !== exp_hex(M_SHOW, k)) begin errors++; $display("FAIL busy_start hex got=%h exp=%h", hex_all(), exp_hex(M_SHOW, k)); end
    checks++; if (bus.cycles !== 32'(ex - entry_edge)) begin errors++; $display("FAIL busy_start cycles got=%0d exp=%0d", bus.cycles, ex - entry_edge); end
  endtask

  // Reset while waiting for completion, with rdy rising during reset; run restarts afterwards
  task automatic test_reset_mid_run();
    int p0, ex, sb, n;
    bit tmo;
    logic [23:0] k;
    p0 = en_pulses;
    pulse_start();
    n = 0;
    while (bus.crack_en !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++; if (bus.crack_en !== 1'b1) begin errors++; $display("FAIL mid_reset en_wait got=%b exp=1", bus.crack_en); end
    bus.crack_rdy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus.crack_rdy = 1'b1;
    bus.key_valid = 1'b1;
    bus.key = 24'($urandom);
    @(negedge clk);
    checks++; if ({status(), bus.cycles} !== {4'b0000, 32'd0}) begin errors++; $display("FAIL mid_reset outputs got=%b/%0d exp=0000/0", status(), bus.cycles); end
    checks++; if (hex_all() !== exp_hex(M_BLANK, '0)) begin errors++; $display("FAIL mid_reset hex got=%h exp=%h", hex_all(), exp_hex(M_BLANK, '0)); end
    entry_edge = edge_cnt + 1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (status() !== 4'b1000) begin errors++; $display("FAIL mid_reset restart_status got=%b exp=1000", status()); end
    k = 24'($urandom);
    engine_run(1'b1, k, 3, 0, 1'b0, ex, tmo, sb);
    checks++; if (tmo) begin errors++; $display("FAIL mid_reset timeout got=1 exp=0"); end
    checks++; if (en_pulses - p0 != 2) begin errors++; $display("FAIL mid_reset pulses got=%0d exp=2", en_pulses - p0); end
    checks++; if (hex_all() !== exp_hex(M_SHOW, k)) begin errors++; $display("FAIL mid_reset hex_after got=%h exp=%h", hex_all(), exp_hex(M_SHOW, k)); end
    checks++; if (bus.cycles !== 32'(ex - entry_edge)) begin errors++; $display("FAIL mid_reset cycles got=%0d exp=%0d", bus.cycles, ex - entry_edge); end
  endtask

  // Randomized back-to-back runs
  task automatic test_random_runs();
    int p0, ex, sb;
    bit tmo, kv;
    logic [23:0] k;
    for (int i = 0; i < 8; i++) begin
      p0 = en_pulses;
      kv = 1'($urandom);
      k = 24'($urandom);
      pulse_start();
      engine_run(kv, k, int'($urandom_range(1, 12)), int'($urandom_range(0, 3)), 1'($urandom), ex, tmo, sb);
      checks++; if (tmo || sb != 0) begin errors++; $display("FAIL rand[%0d] protocol got=tmo%0d/stale%0d exp=0/0", i, tmo, sb); end
      checks++; if (en_pulses - p0 != 1) begin errors++; $display("FAIL rand[%0d] pulses got=%0d exp=1", i, en_pulses - p0); end
      checks++; if (status() !== (kv ? 4'b0100 : 4'b0010)) begin errors++; $display("FAIL rand[%0d] status got=%b exp=%b", i, status(), kv ? 4'b0100 : 4'b0010); end
      checks++; if (hex_all() !== exp_hex(kv ? M_SHOW : M_FAIL, k)) begin errors++; $display("FAIL rand[%0d] hex got=%h exp=%h", i, hex_all(), exp_hex(kv ? M_SHOW : M_FAIL, k)); end
      checks++; if (bus.cycles !== 32'(ex - entry_edge)) begin errors++; $display("FAIL rand[%0d] cycles got=%0d exp=%0d", i, bus.cycles, ex - entry_edge); end
    end
  endtask

  initial begin
    test_reset();
    test_rdy_held_low();
    test_found_key();
    test_fail();
    test_stale_rdy();
    test_start_while_busy();
    test_reset_mid_run();
    test_random_runs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/crack_result_ctrl.md
CRACK_RESULT_CTRL -- requirements
Module: crack_result_ctrl

Interface
REQ-001 Parameter AUTO_START, default 1: when 1, a crack run is requested automatically after reset without a start pulse.
REQ-002 Parameter CNT_W, default 32: width of the run-cycle counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a new crack run.
REQ-006 crack_rdy  input  1  crack engine ready to accept en.
REQ-007 crack_en  output  1  one-cycle start pulse to the crack engine.
REQ-008 key  input  24  key reported by the crack engine.
REQ-009 key_valid  input  1  engine found a key; meaningful when crack_rdy returns high.
REQ-010 HEX0..HEX5  output  7 each  active-low seven-segment digits; bit0=a .. bit6=g; HEX5 most significant.
REQ-011 busy  output  1  high while a run is in progress.
REQ-012 found  output  1  high while a found key is displayed.
REQ-013 failed  output  1  high while a failed run is displayed.
REQ-014 cycles  output  CNT_W  clk cycles elapsed in the last or current run.

Function
REQ-015 FSM states: IDLE, REQ, WLOW, WHIGH, SHOW, FAIL.
REQ-016 IDLE -> REQ on start, or on the first cycle after reset when AUTO_START=1.
REQ-017 In REQ, crack_en is driven high for exactly one cycle, in the first cycle crack_rdy=1, then the FSM moves to WLOW; while crack_rdy=0 it stays in REQ with crack_en low.
REQ-018 WLOW -> WHIGH when crack_rdy=0, so that a stale high rdy is never taken as completion.
REQ-019 WHIGH: on the first cycle with crack_rdy=1, key_valid=1 -> SHOW with key latched, and key_valid=0 -> FAIL.
REQ-020 The latched key is captured in the same edge as the WHIGH exit and is held until the next entry into SHOW.
REQ-021 SHOW: HEXn displays latched_key[4n+3:4n] using the active-low hex encoding 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 (written g..a).
REQ-022 FAIL: all six HEX outputs show dash 0111111.
REQ-023 IDLE, REQ, WLOW and WHIGH: all six HEX outputs are blank (1111111).
REQ-024 busy=1 in REQ, WLOW and WHIGH; found=1 only in SHOW; failed=1 only in FAIL; the three are mutually exclusive.
REQ-025 cycles is cleared to 0 on the REQ entry edge, increments by 1 each cycle in REQ, WLOW and WHIGH, saturates at all-ones, and holds in SHOW, FAIL and IDLE.
REQ-026 SHOW or FAIL -> REQ on start (re-run), with the display blanked from the next cycle.
REQ-027 start is ignored while busy=1.
REQ-028 key and key_valid are ignored outside WHIGH.
REQ-029 All outputs are registered; the HEX outputs update on the cycle after the state change.

Reset
REQ-030 rst has priority over every other input and returns the block to IDLE in one cycle, including during a run.
REQ-031 Reset values: crack_en=0, busy=0, found=0, failed=0, cycles=0, latched key=0, all HEX=1111111.
REQ-032 With AUTO_START=1, the REQ state is entered on the first cycle after rst deasserts.
REQ-033 A crack_rdy rising while rst is high has no effect.

Verification
REQ-034 AUTO_START=1; engine model drops rdy for 100 cycles, then rdy=1, key_valid=1, key=24'h00033C -> exactly one crack_en pulse; HEX5..HEX0 = 0,0,0,3,3,C encodings; found=1; cycles is approximately 101 (exact per the model).
REQ-035 Engine returns key_valid=0 -> failed=1, all HEX=0111111, found=0.
REQ-036 crack_rdy held low for 20 cycles after reset -> crack_en stays 0 until rdy=1, then pulses exactly once.
REQ-037 crack_rdy kept high for 5 cycles after crack_en -> no completion is detected until rdy falls and then rises again.
REQ-038 rst asserted mid-run (WHIGH) -> next cycle: IDLE, outputs at reset values, no display update; the run restarts (AUTO_START=1).
REQ-039 start pulse in SHOW -> HEX blank, cycles=0, new crack_en pulse; start pulses while busy -> no extra crack_en.
